// File: rtl/v_lut_scan.sv
// Scan initiator for the list table: issues pipelined level lookups for one product,
// buffers in-order responses in a small FIFO and streams them out with a last marker.
module v_lut_scan #(
  parameter int FIFO_N  = 4,
  parameter int LEVEL_N = 8,
  parameter int ID_W    = 4,
  parameter int KEY_W   = 16,
  parameter int SIZE_W  = 8,
  parameter int LEVEL_W = $clog2(LEVEL_N),
  parameter int LS_W    = LEVEL_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_busy,
  input  logic               i_scan_vld,
  input  logic [ID_W-1:0]    i_scan_prod_id,
  input  logic [LEVEL_W:0]   i_scan_levels,
  output logic               o_scan_rdy,
  output logic               o_lut_vld_r,
  output logic [ID_W-1:0]    o_lut_prod_id_r,
  output logic [LEVEL_W-1:0] o_lut_level_r,
  input  logic               i_lut_vld_r,
  input  logic [KEY_W-1:0]   i_lut_key,
  input  logic [SIZE_W-1:0]  i_lut_size,
  input  logic               i_lut_error,
  input  logic [LS_W-1:0]    i_lut_listsize,
  output logic               o_ent_vld,
  output logic [LEVEL_W-1:0] o_ent_level,
  output logic [KEY_W-1:0]   o_ent_key,
  output logic [SIZE_W-1:0]  o_ent_size,
  output logic               o_ent_err,
  output logic               o_ent_last,
  input  logic               i_ent_rdy,
  output logic               o_scan_busy_r
);

  localparam int CNT_W = $clog2(FIFO_N + 1);
  localparam int PTR_W = (FIFO_N > 1) ? $clog2(FIFO_N) : 1;
  localparam int LC_W  = LEVEL_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  typedef struct packed {
    logic [LEVEL_W-1:0] level;
    logic [KEY_W-1:0]   key;
    logic [SIZE_W-1:0]  size;
    logic               err;
    logic               last;
  } ent_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    prod_q, prod_d;
  logic [LC_W-1:0]    lim_q, lim_d;
  logic [LC_W-1:0]    next_lvl_q, next_lvl_d;
  logic [LC_W-1:0]    rsp_lvl_q, rsp_lvl_d;
  logic               stop_q, stop_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               lut_vld_q, lut_vld_d;
  logic [ID_W-1:0]    lut_prod_q, lut_prod_d;
  logic [LEVEL_W-1:0] lut_level_q, lut_level_d;
  logic               scan_busy_q, scan_busy_d;

  ent_t               fifo_mem [FIFO_N];
  ent_t               push_ent;
  ent_t               head_ent;
  logic               issue, rsp, push, pop;
  logic [LC_W:0]      lvl_p1;
  logic [CNT_W:0]     credit_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_N - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    prod_d      = prod_q;
    lim_d       = lim_q;
    next_lvl_d  = next_lvl_q;
    rsp_lvl_d   = rsp_lvl_q;
    stop_d      = stop_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    lut_vld_d   = 1'b0;
    lut_prod_d  = lut_prod_q;
    lut_level_d = lut_level_q;

    // FIFO entries plus outstanding lookups never exceed the FIFO depth,
    // so every response that must be kept always has a free slot.
    credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    issue = (state_q == S_ISSUE) && !i_busy && !stop_q && (next_lvl_q < lim_q) &&
            (credit_used < (CNT_W + 1)'(FIFO_N));
    rsp   = i_lut_vld_r && (state_q != S_IDLE) && (inflight_q != '0);
    pop   = (fifo_cnt_q != '0) && i_ent_rdy;
    push  = rsp && !stop_q;

    lvl_p1         = {1'b0, rsp_lvl_q} + 1'b1;
    push_ent.level = rsp_lvl_q[LEVEL_W-1:0];
    push_ent.key   = i_lut_error ? '0 : i_lut_key;
    push_ent.size  = i_lut_error ? '0 : i_lut_size;
    push_ent.err   = i_lut_error;
    push_ent.last  = i_lut_error || (lvl_p1 >= (LC_W + 1)'(i_lut_listsize)) ||
                     (lvl_p1 == {1'b0, lim_q});

    case (state_q)
      S_IDLE: begin
        if (i_scan_vld) begin
          state_d    = S_ISSUE;
          prod_d     = i_scan_prod_id;
          next_lvl_d = '0;
          rsp_lvl_d  = '0;
          stop_d     = 1'b0;
          if (i_scan_levels == '0)
            lim_d = LC_W'(1);
          else if (i_scan_levels > LC_W'(LEVEL_N))
            lim_d = LC_W'(LEVEL_N);
          else
            lim_d = i_scan_levels;
        end
      end
      S_ISSUE: if (stop_q) state_d = S_DRAIN;
      S_DRAIN: if ((inflight_q == '0) && (fifo_cnt_q == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      lut_vld_d   = 1'b1;
      lut_prod_d  = prod_q;
      lut_level_d = next_lvl_q[LEVEL_W-1:0];
      next_lvl_d  = next_lvl_q + 1'b1;
    end

    if (rsp) rsp_lvl_d = rsp_lvl_q + 1'b1;
    if (push && push_ent.last) stop_d = 1'b1;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    inflight_d  = inflight_q + CNT_W'(issue) - CNT_W'(rsp);
    fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    scan_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prod_q      <= '0;
      lim_q       <= '0;
      next_lvl_q  <= '0;
      rsp_lvl_q   <= '0;
      stop_q      <= 1'b0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lut_vld_q   <= 1'b0;
      lut_prod_q  <= '0;
      lut_level_q <= '0;
      scan_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prod_q      <= prod_d;
      lim_q       <= lim_d;
      next_lvl_q  <= next_lvl_d;
      rsp_lvl_q   <= rsp_lvl_d;
      stop_q      <= stop_d;
      inflight_q  <= inflight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lut_vld_q   <= lut_vld_d;
      lut_prod_q  <= lut_prod_d;
      lut_level_q <= lut_level_d;
      scan_busy_q <= scan_busy_d;
    end
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_ent;
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (fifo_cnt_q == CNT_W'(FIFO_N))));

  assign head_ent        = fifo_mem[rd_ptr_q];
  assign o_scan_rdy      = (state_q == S_IDLE);
  assign o_lut_vld_r     = lut_vld_q;
  assign o_lut_prod_id_r = lut_prod_q;
  assign o_lut_level_r   = lut_level_q;
  assign o_ent_vld       = (fifo_cnt_q != '0);
  assign o_ent_level     = head_ent.level;
  assign o_ent_key       = head_ent.key;
  assign o_ent_size      = head_ent.size;
  assign o_ent_err       = head_ent.err;
  assign o_ent_last      = head_ent.last;
  assign o_scan_busy_r   = scan_busy_q;

endmodule
